// File: rtl/icap_s6_pkg.sv
// Shared constants, state encoding and helpers for the Spartan-6 ICAP
// register sequencer.
package icap_s6_pkg;

    localparam logic [15:0] W_DUMMY   = 16'hFFFF;
    localparam logic [15:0] W_SYNC0   = 16'hAA99;
    localparam logic [15:0] W_SYNC1   = 16'h5566;
    localparam logic [15:0] W_NOOP    = 16'h2000;
    localparam logic [15:0] W_CMD_HDR = 16'h30A1;
    localparam logic [15:0] W_DESYNC  = 16'h000D;

    localparam logic [2:0] PKT_TYPE1 = 3'b001;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [4:0] WCNT_ONE  = 5'b00001;

    localparam int WR_LEN  = 10;
    localparam int RDH_LEN = 7;
    localparam int DS_LEN  = 4;

    localparam logic [3:0] WR_LAST  = 4'(WR_LEN - 1);
    localparam logic [3:0] RDH_LAST = 4'(RDH_LEN - 1);
    localparam logic [3:0] DS_LAST  = 4'(DS_LEN - 1);

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_SEQ,
        ST_RD_HEAD,
        ST_TURN_R,
        ST_RD,
        ST_TURN_W,
        ST_DESYNC,
        ST_DONE
    } state_e;

    // Reverse the bit order inside each byte; self-inverse.
    function automatic logic [15:0] bit_swap16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8+i]   = w[15-i];
        end
        return r;
    endfunction

    function automatic logic [15:0] type1_hdr(
        input logic [1:0] op,
        input logic [5:0] addr
    );
        return {PKT_TYPE1, op, addr, WCNT_ONE};
    endfunction

endpackage

// File: rtl/icap_s6_word_sel.sv
// Combinational ICAP_I word selection from state/index/address/data.
// Ports: state_i, idx_i, addr_i, wdata_i in; word_o out (post bit swap).
module icap_s6_word_sel
    import icap_s6_pkg::*;
#(
    parameter bit BIT_SWAP = 1'b1
) (
    input  state_e      state_i,
    input  logic [3:0]  idx_i,
    input  logic [5:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] word_o
);

    logic [15:0] raw;

    always_comb begin
        raw = W_DUMMY;
        unique case (state_i)
            ST_WR_SEQ: begin
                case (idx_i)
                    4'd0:    raw = W_DUMMY;
                    4'd1:    raw = W_SYNC0;
                    4'd2:    raw = W_SYNC1;
                    4'd3:    raw = W_NOOP;
                    4'd4:    raw = type1_hdr(OP_WRITE, addr_i);
                    4'd5:    raw = wdata_i;
                    4'd6:    raw = W_CMD_HDR;
                    4'd7:    raw = W_DESYNC;
                    default: raw = W_NOOP;
                endcase
            end
            ST_RD_HEAD: begin
                case (idx_i)
                    4'd0:    raw = W_DUMMY;
                    4'd1:    raw = W_SYNC0;
                    4'd2:    raw = W_SYNC1;
                    4'd3:    raw = W_NOOP;
                    4'd4:    raw = type1_hdr(OP_READ, addr_i);
                    default: raw = W_NOOP;
                endcase
            end
            ST_DESYNC: begin
                case (idx_i)
                    4'd0:    raw = W_CMD_HDR;
                    4'd1:    raw = W_DESYNC;
                    default: raw = W_NOOP;
                endcase
            end
            default: raw = W_DUMMY;
        endcase
    end

    assign word_o = BIT_SWAP ? bit_swap16(raw) : raw;

endmodule

// File: rtl/icap_s6_reg_ctrl.sv
// Single 16-bit config register read/write sequencer for Spartan-6 ICAP.
// Host side: REQ/REQ_WR/REQ_ADDR/REQ_WDATA in; READY/ACK/ERR/RDATA out.
// ICAP side: ICAP_CE/ICAP_WRITE/ICAP_I out (registered); ICAP_O/ICAP_BUSY in.
module icap_s6_reg_ctrl
    import icap_s6_pkg::*;
#(
    parameter bit          BIT_SWAP = 1'b1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        REQ,
    input  logic        REQ_WR,
    input  logic [5:0]  REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    output logic        READY,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic        ICAP_CE,
    output logic        ICAP_WRITE,
    output logic [15:0] ICAP_I,
    input  logic [15:0] ICAP_O,
    input  logic        ICAP_BUSY
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        wr_q, wr_d;
    logic [5:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rbuf_q, rbuf_d;
    logic        rerr_q, rerr_d;

    logic        ready_q, ready_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ce_q, ce_d;
    logic        we_q, we_d;
    logic [15:0] icap_i_q, icap_i_d;
    logic [15:0] word;

    // State and working registers
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            tcnt_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rerr_q  <= rerr_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            ST_INIT: begin
                if (!ICAP_BUSY) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (REQ) begin
                    wr_d    = REQ_WR;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    idx_d   = '0;
                    rerr_d  = 1'b0;
                    state_d = REQ_WR ? ST_WR_SEQ : ST_RD_HEAD;
                end
            end
            ST_WR_SEQ: begin
                if (!ICAP_BUSY) begin
                    if (idx_q == WR_LAST) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_RD_HEAD: begin
                if (!ICAP_BUSY) begin
                    if (idx_q == RDH_LAST) begin
                        idx_d   = '0;
                        state_d = ST_TURN_R;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_TURN_R: begin
                tcnt_d  = '0;
                state_d = ST_RD;
            end
            ST_RD: begin
                if (!ICAP_BUSY) begin
                    rbuf_d  = BIT_SWAP ? bit_swap16(ICAP_O) : ICAP_O;
                    state_d = ST_TURN_W;
                end else if (tcnt_q == TO_LAST) begin
                    rbuf_d  = '0;
                    rerr_d  = 1'b1;
                    state_d = ST_TURN_W;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            ST_TURN_W: begin
                idx_d   = '0;
                state_d = ST_DESYNC;
            end
            ST_DESYNC: begin
                if (!ICAP_BUSY) begin
                    if (idx_q == DS_LAST) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    icap_s6_word_sel #(
        .BIT_SWAP (BIT_SWAP)
    ) u_word_sel (
        .state_i (state_d),
        .idx_i   (idx_d),
        .addr_i  (addr_d),
        .wdata_i (wdata_d),
        .word_o  (word)
    );

    // Outputs are computed from the next state so that the registered
    // pins line up with the state they belong to.
    always_comb begin
        ready_d  = (state_d == ST_IDLE);
        ack_d    = (state_d == ST_DONE);
        ce_d     = 1'b1;
        we_d     = 1'b0;
        icap_i_d = word;
        err_d    = err_q;
        rdata_d  = rdata_q;
        unique case (state_d)
            ST_WR_SEQ, ST_RD_HEAD, ST_DESYNC: begin
                ce_d = 1'b0;
                we_d = 1'b0;
            end
            ST_TURN_R: begin
                ce_d = 1'b1;
                we_d = 1'b1;
            end
            ST_RD: begin
                ce_d = 1'b0;
                we_d = 1'b1;
            end
            ST_DONE: begin
                if (wr_q) begin
                    err_d = 1'b0;
                end else begin
                    err_d   = rerr_q;
                    rdata_d = rbuf_q;
                end
            end
            default: begin
                ce_d = 1'b1;
                we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            ce_q     <= 1'b1;
            we_q     <= 1'b0;
            icap_i_q <= 16'hFFFF;
        end else begin
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            icap_i_q <= icap_i_d;
        end
    end

    assign READY      = ready_q;
    assign ACK        = ack_q;
    assign ERR        = err_q;
    assign RDATA      = rdata_q;
    assign ICAP_CE    = ce_q;
    assign ICAP_WRITE = we_q;
    assign ICAP_I     = icap_i_q;

endmodule

// File: tb/tb_icap_s6_reg_ctrl.sv
// Randomized self-checking bench for icap_s6_reg_ctrl against a
// word-stream / latency reference model.
module tb_icap_s6_reg_ctrl;

    localparam int TO = 8;

    logic        CLK;
    logic        RST_B;
    logic        REQ;
    logic        REQ_WR;
    logic [5:0]  REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic        READY;
    logic        ACK;
    logic        ERR;
    logic [15:0] RDATA;
    logic        ICAP_CE;
    logic        ICAP_WRITE;
    logic [15:0] ICAP_I;
    logic [15:0] ICAP_O;
    logic        ICAP_BUSY;

    int n_checks;
    int n_fail;
    int cyc;
    logic [15:0] last_rdata;

    icap_s6_reg_ctrl #(
        .BIT_SWAP (1'b0),
        .TIMEOUT  (TO)
    ) dut (
        .CLK        (CLK),
        .RST_B      (RST_B),
        .REQ        (REQ),
        .REQ_WR     (REQ_WR),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .READY      (READY),
        .ACK        (ACK),
        .ERR        (ERR),
        .RDATA      (RDATA),
        .ICAP_CE    (ICAP_CE),
        .ICAP_WRITE (ICAP_WRITE),
        .ICAP_I     (ICAP_I),
        .ICAP_O     (ICAP_O),
        .ICAP_BUSY  (ICAP_BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected ICAP word stream, straight from the packet definitions.
    task automatic build_stream(input bit wr, input logic [5:0] addr,
                                input logic [15:0] wd,
                                output logic [15:0] s[$]);
        s = {};
        s.push_back(16'hFFFF);
        s.push_back(16'hAA99);
        s.push_back(16'h5566);
        s.push_back(16'h2000);
        if (wr) begin
            s.push_back({3'b001, 2'b10, addr, 5'b00001});
            s.push_back(wd);
        end else begin
            s.push_back({3'b001, 2'b01, addr, 5'b00001});
            s.push_back(16'h2000);
            s.push_back(16'h2000);
        end
        s.push_back(16'h30A1);
        s.push_back(16'h000D);
        s.push_back(16'h2000);
        s.push_back(16'h2000);
    endtask

    // hold_idx/hold_n: force BUSY on one word; rnd: random BUSY elsewhere.
    task automatic run_txn(input bit wr, input logic [5:0] addr,
                           input logic [15:0] wd, input int hold_idx,
                           input int hold_n, input bit rnd, input bit stuck,
                           input int rd_pre, input logic [15:0] rd_val,
                           input string nm);
        logic [15:0] exp_q[$];
        logic [15:0] got_q[$];
        int hold_plan[16];
        int t, ack_cyc, rd_cyc, w_cnt, held, guard, sum_hold, exp_lat;
        int exp_rd;
        bit acked, prev_we, viol, hold_bad;
        logic [15:0] exp_rdata;

        build_stream(wr, addr, wd, exp_q);
        got_q = {};
        sum_hold = 0;
        for (int i = 0; i < 16; i++) begin
            hold_plan[i] = 0;
            if (rnd && i < exp_q.size()) hold_plan[i] = $urandom_range(0, 2);
            if (i == hold_idx) hold_plan[i] = hold_n;
            if (i < exp_q.size()) sum_hold += hold_plan[i];
        end

        guard = 0;
        while (!READY && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check({nm, "_ready"}, 32'(READY), 32'd1);

        REQ       = 1'b1;
        REQ_WR    = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        ICAP_BUSY = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        t = cyc;
        ack_cyc = 0;
        prev_we = ICAP_WRITE;
        acked = 0;
        viol = 0;
        hold_bad = 0;
        rd_cyc = 0;
        w_cnt = 0;
        held = 0;
        guard = 0;
        while (!acked && guard < 200) begin
            @(negedge CLK);
            guard++;
            if (ICAP_WRITE != prev_we && !ICAP_CE) viol = 1;
            prev_we = ICAP_WRITE;
            ICAP_O = 16'($urandom);
            if (ACK) begin
                acked = 1;
                ack_cyc = cyc;
                ICAP_BUSY = 1'b0;
            end else if (!ICAP_CE && !ICAP_WRITE) begin
                if (w_cnt < 16 && held < hold_plan[w_cnt]) begin
                    ICAP_BUSY = 1'b1;
                    held++;
                    if (w_cnt < exp_q.size() && ICAP_I != exp_q[w_cnt])
                        hold_bad = 1;
                end else begin
                    ICAP_BUSY = 1'b0;
                    got_q.push_back(ICAP_I);
                    w_cnt++;
                    held = 0;
                end
            end else if (!ICAP_CE && ICAP_WRITE) begin
                rd_cyc++;
                if (stuck || rd_cyc <= rd_pre) begin
                    ICAP_BUSY = 1'b1;
                end else begin
                    ICAP_BUSY = 1'b0;
                    ICAP_O = rd_val;
                end
            end else begin
                ICAP_BUSY = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        REQ = 1'b0;

        check({nm, "_acked"}, 32'(acked), 32'd1);
        check({nm, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", nm, i), 32'(got_q[i]),
                  32'(exp_q[i]));
        check({nm, "_hold_word"}, 32'(hold_bad), 32'd0);
        check({nm, "_we_ce"}, 32'(viol), 32'd0);

        exp_rd = wr ? 0 : (stuck ? TO : rd_pre + 1);
        exp_lat = 1 + exp_q.size() + sum_hold + (wr ? 0 : 2 + exp_rd);
        check({nm, "_rd_cycles"}, 32'(rd_cyc), 32'(exp_rd));
        check({nm, "_ack_lat"}, 32'(ack_cyc - t), 32'(exp_lat));
        if (wr) exp_rdata = last_rdata;
        else exp_rdata = stuck ? 16'h0000 : rd_val;
        check({nm, "_err"}, 32'(ERR), 32'(!wr && stuck));
        check({nm, "_rdata"}, 32'(RDATA), 32'(exp_rdata));
        last_rdata = exp_rdata;

        @(negedge CLK);
        check({nm, "_ack_pulse"}, 32'(ACK), 32'd0);
        check({nm, "_idle"}, 32'(READY), 32'd1);
    endtask

    int bad;

    initial begin
        n_checks = 0;
        n_fail = 0;
        last_rdata = 16'h0000;
        RST_B = 1'b1;
        REQ = 1'b0;
        REQ_WR = 1'b0;
        REQ_ADDR = '0;
        REQ_WDATA = '0;
        ICAP_O = '0;
        ICAP_BUSY = 1'b1;
        #3 RST_B = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(READY), 32'd0);
        check("rst_ack", 32'(ACK), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_rdata", 32'(RDATA), 32'h0);
        check("rst_ce", 32'(ICAP_CE), 32'd1);
        check("rst_we", 32'(ICAP_WRITE), 32'd0);
        check("rst_icap_i", 32'(ICAP_I), 32'hFFFF);
        RST_B = 1'b1;

        bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (READY || !ICAP_CE) bad++;
        end
        check("init_hold", 32'(bad), 32'd0);
        ICAP_BUSY = 1'b0;
        check("init_ready_same", 32'(READY), 32'd0);
        @(negedge CLK);
        check("init_ready_next", 32'(READY), 32'd1);

        run_txn(1, 6'h05, 16'h000D, -1, 0, 0, 0, 0, 16'h0, "wr05");
        run_txn(0, 6'h0E, 16'h0, -1, 0, 0, 0, 0, 16'h1234, "rd0E");
        run_txn(1, 6'h05, 16'h000D, 4, 3, 0, 0, 0, 16'h0, "wrhold");
        run_txn(0, 6'h0E, 16'h0, -1, 0, 0, 1, 0, 16'h0, "rdto");
        run_txn(1, 6'h11, 16'hBEEF, -1, 0, 0, 0, 0, 16'h0, "wrkeep");

        REQ = 1'b1;
        REQ_WR = 1'b1;
        REQ_ADDR = 6'h07;
        REQ_WDATA = 16'h5A5A;
        repeat (5) @(negedge CLK);
        check("mid_ce_low", 32'(ICAP_CE), 32'd0);
        RST_B = 1'b0;
        #1;
        check("mid_rst_ce", 32'(ICAP_CE), 32'd1);
        check("mid_rst_icap_i", 32'(ICAP_I), 32'hFFFF);
        check("mid_rst_ready", 32'(READY), 32'd0);
        check("mid_rst_rdata", 32'(RDATA), 32'h0);
        REQ = 1'b0;
        last_rdata = 16'h0000;
        @(negedge CLK);
        RST_B = 1'b1;
        ICAP_BUSY = 1'b0;
        run_txn(1, 6'h07, 16'h5A5A, -1, 0, 0, 0, 0, 16'h0, "wrafter");

        for (int k = 0; k < 20; k++) begin
            run_txn(1'($urandom_range(0, 1)), 6'($urandom),
                    16'($urandom), -1, 0, 1,
                    ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 5), 16'($urandom),
                    $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
